// File: rtl/capture_buffer.sv
// Circular sample RAM and write/readout controller for the logic analyzer.
// Optional stop timestamp: define CAPTURE_TIMESTAMP_EN.
module capture_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int TS_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_sample_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_stopped,
  input  logic                  i_rearm,
  input  logic                  i_rd_start,
  input  logic                  i_rd_ready,
  output logic                  o_primed,
  output logic                  o_done,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_last,
`ifdef CAPTURE_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]   o_stop_ts,
`endif
  output logic                  o_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] C_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] C_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    FILL, PRIMED, FROZEN, READ, IDLE
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH-1:0] start_ptr;
  logic [ADDR_WIDTH:0]   fill_cnt;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic                  inflight;
  logic                  inflight_last;
  logic                  we;
  logic                  accept;
  logic                  issue;
  logic                  freeze;

  always_comb begin
    freeze = !i_rearm && state == PRIMED && i_stopped;
    we     = !i_rearm && i_sample_en &&
             (state == FILL || (state == PRIMED && !i_stopped));
    accept = o_rd_valid && i_rd_ready;
    // One read in flight; issue only if the output slot frees up.
    issue  = !i_rearm && state == READ && rd_cnt != C_FULL &&
             !inflight && (!o_rd_valid || accept);
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[wptr] <= i_data;
    ram_q <= mem[rptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= FILL;
      wptr          <= '0;
      rptr          <= '0;
      start_ptr     <= '0;
      fill_cnt      <= '0;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      o_primed      <= 1'b0;
      o_done        <= 1'b0;
      o_busy        <= 1'b0;
      o_rd_valid    <= 1'b0;
      o_rd_data     <= '0;
      o_rd_last     <= 1'b0;
    end else if (i_rearm) begin
      state         <= FILL;
      wptr          <= '0;
      rptr          <= '0;
      fill_cnt      <= '0;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      o_primed      <= 1'b0;
      o_done        <= 1'b0;
      o_busy        <= 1'b0;
      o_rd_valid    <= 1'b0;
      o_rd_data     <= '0;
      o_rd_last     <= 1'b0;
    end else begin
      if (we)
        wptr <= wptr + A_ONE;
      inflight <= issue;
      if (issue) begin
        rptr          <= rptr + A_ONE;
        rd_cnt        <= rd_cnt + C_ONE;
        inflight_last <= rd_cnt == C_LAST;
      end
      if (inflight) begin
        o_rd_valid <= 1'b1;
        o_rd_data  <= ram_q;
        o_rd_last  <= inflight_last;
      end else if (accept) begin
        o_rd_valid <= 1'b0;
        o_rd_last  <= 1'b0;
      end
      unique case (state)
        FILL: begin
          if (we) begin
            fill_cnt <= fill_cnt + C_ONE;
            if (fill_cnt == C_LAST) begin
              state    <= PRIMED;
              o_primed <= 1'b1;
            end
          end
        end
        PRIMED: begin
          if (freeze) begin
            state     <= FROZEN;
            start_ptr <= wptr;
            o_done    <= 1'b1;
          end
        end
        FROZEN, IDLE: begin
          if (i_rd_start) begin
            state  <= READ;
            rptr   <= start_ptr;
            rd_cnt <= '0;
            o_busy <= 1'b1;
          end
        end
        READ: begin
          if (accept && o_rd_last) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt    <= '0;
      o_stop_ts <= '0;
    end else if (i_rearm) begin
      ts_cnt    <= '0;
      o_stop_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
      if (freeze)
        o_stop_ts <= ts_cnt;
    end
  end
`endif

endmodule

// File: doc/capture_buffer.md
Name: capture_buffer

Overview:
- Sample memory and write controller for the internal logic analyzer.
- Writes probe samples into a circular RAM and raises o_primed once the RAM has been completely filled. This feeds the primed input of the trigger/holdoff stop stage.
- Consumes that stage's stopped output to freeze the capture, then streams the frozen window out oldest-first over a valid/ready readout port.

Parameters:
- DATA_WIDTH, 8: probe sample width in bits.
- ADDR_WIDTH, 10: RAM address width; DEPTH = 2**ADDR_WIDTH samples.
- TS_WIDTH, 32: timestamp counter width; used only with the optional feature.

Ports:
- clk  input  1  sampling/system clock.
- reset  input  1  asynchronous, active-low reset.
- i_sample_en  input  1  qualifies i_data this cycle.
- i_data  input  DATA_WIDTH  probe sample.
- i_stopped  input  1  from stop stage; level, held high until that stage is reset.
- i_rearm  input  1  single-cycle pulse; restart capture.
- i_rd_start  input  1  single-cycle pulse; begin readout.
- i_rd_ready  input  1  readout consumer ready.
- o_primed  output  1  RAM fully written at least once since arm.
- o_done  output  1  capture frozen, window available.
- o_rd_valid  output  1  o_rd_data valid.
- o_rd_data  output  DATA_WIDTH  readout sample.
- o_rd_last  output  1  with o_rd_valid: final (newest) sample.
- o_busy  output  1  readout in progress.

Behaviour:
- States: FILL, PRIMED, FROZEN, READ, IDLE.
- Reset (reset=0, async):
  - State goes to FILL.
  - wptr=0, fill_cnt=0, rptr=0, rd_cnt=0.
  - All outputs 0.
  - Output register cleared.
- FILL:
  - Each cycle with i_sample_en=1: RAM[wptr]<=i_data, wptr<=wptr+1 (wraps modulo DEPTH), fill_cnt++.
  - fill_cnt is ADDR_WIDTH+1 bits wide.
  - When the write that brings fill_cnt to DEPTH occurs, go to PRIMED. o_primed=1 from the next cycle.
  - i_stopped is ignored in FILL.
- PRIMED:
  - Circular writes continue as in FILL. o_primed stays 1.
  - A cycle where i_stopped=1 performs no write. State goes to FROZEN and start_ptr<=wptr (oldest sample).
  - If i_stopped=1 and i_sample_en=1 in the same cycle, the write is suppressed.
- FROZEN:
  - No writes. o_done=1, o_primed=1.
  - i_rd_start=1 goes to READ with rptr<=start_ptr and rd_cnt<=0.
- READ:
  - o_busy=1.
  - Synchronous RAM with 1-cycle read latency, feeding a 1-entry output register (o_rd_valid/o_rd_data).
  - A new RAM read is issued when rd_cnt<DEPTH and the output register will be empty next cycle (empty, or o_rd_valid&&i_rd_ready).
  - Each issued read increments rptr (wrapping) and rd_cnt.
  - At most one read is in flight. Issue policy is an implementation choice, but no sample may be dropped or duplicated while i_rd_ready is low.
  - o_rd_data is stable while o_rd_valid=1 and i_rd_ready=0.
  - Exactly DEPTH beats are transferred. o_rd_last=1 on beat DEPTH.
  - Accepting the last beat (o_rd_valid&&o_rd_last&&i_rd_ready) goes to IDLE the next cycle, with o_rd_valid=0 and o_busy=0.
- IDLE:
  - o_done=1 is retained and the RAM contents are retained.
  - i_rd_start=1 re-reads the same window (goes to READ from start_ptr).
- i_rearm:
  - Valid in any state; takes priority over every other input.
  - Next cycle: FILL, with wptr=0, fill_cnt=0, o_primed=0, o_done=0, o_busy=0.
  - The output register is flushed and any in-flight read is discarded.
  - The system controller must also reset the stop stage, since i_stopped remains high until that stage is reset.
- i_rd_start outside FROZEN/IDLE is ignored.
- Reset asserted mid-READ: all outputs drop immediately (async).

Optional Feature:
- Macro: CAPTURE_TIMESTAMP_EN.
- When defined:
  - Adds output o_stop_ts [TS_WIDTH-1:0].
  - A free-running cycle counter starts at 0 after reset and on i_rearm, and wraps at 2**TS_WIDTH.
  - On the PRIMED->FROZEN transition its value is latched into o_stop_ts and held until rearm/reset.
  - o_stop_ts is 0 after reset.
- When not defined: no port, no counter, no added logic.

Test Plan (ADDR_WIDTH=4, DEPTH=16, DATA_WIDTH=8):
- Reset, then i_sample_en=1 with i_data=0x00..0x0F over 16 cycles -> o_primed rises the cycle after data 0x0F; o_done=0.
- Continue with data 0x10..0x14, assert i_stopped in the same cycle as 0x15 -> 0x15 not written; o_done=1; readout with i_rd_ready=1 yields 0x05..0x14, o_rd_last on 0x14, 16 beats.
- i_stopped held high during FILL (after 5 samples) -> no freeze; o_primed rises after the 16th sample; freeze happens on the next cycle.
- Readout with i_rd_ready toggled 1,0,0,1 repeatedly -> same 16-beat sequence; data stable while stalled; no duplicates or gaps; o_busy falls after the last accept.
- i_rearm pulsed on readout beat 7 -> next cycle o_rd_valid=0, o_done=0, o_primed=0; a fresh fill of 16 requires o_primed again.
- With CAPTURE_TIMESTAMP_EN: freeze on cycle 40 after reset -> o_stop_ts=40; async reset -> o_stop_ts=0 immediately.
